multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Sequencing controller for the multi-cycle RV32I core. It replaces single-cycle decode with a Moore FSM: FETCH, DECODE, EXEC, MEM, WB. It drives PC/IR write enables, the shared instruction/data memory handshake, ALU operand selects and ALUOp, and register-file write-back. It also detects illegal opcodes and memory timeouts and parks the core in a FAULT state.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for mem_ready before FAULT (legal range 2..255)
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT

Ports:
clk  in  1  core clock, single domain
rst  in  1  synchronous, active-high reset
opcode  in  5  instr[6:2] from IR; valid from DECODE onward
mem_ready  in  1  memory completes current access this cycle; ignored when mem_req=0
mem_req  out  1  memory access request, held until mem_ready
mem_we  out  1  write strobe (store in MEM only)
i_or_d  out  1  address mux: 0=PC, 1=ALUOut
ir_write  out  1  load IR from memory read data
pc_write  out  1  unconditional PC update
pc_write_cond  out  1  PC update gated by ALU zero (branch)
pc_src  out  1  0=ALU result (PC+4), 1=ALUOut (branch target)
alu_src_a  out  2  00=PC, 01=rs1, others reserved
alu_src_b  out  2  00=rs2, 01=const 4, 10=imm
alu_op  out  2  00=add, 01=branch compare, 10=R-type funct, 11=I-type funct
reg_write  out  1  register-file write enable
mem_to_reg  out  1  write-back source: 0=ALUOut, 1=MDR
retire  out  1  one-cycle pulse when an instruction completes
fault  out  1  sticky; high while in FAULT

Behaviour:
- State is 3-bit: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5. Unused codes go to FAULT.
- Outputs decode from state and opcode_q. ir_write, pc_write and the MEM-state exit are additionally gated by mem_ready.
- While rst=1, all outputs are 0. On the next edge: state=FETCH, opcode_q=0, counter=0. The first post-reset cycle asserts mem_req.
- Reset mid-operation aborts immediately. No memory write may be issued in the reset cycle.
- Decoded opcodes: R=01100, I-ALU=00100, LOAD=00000, STORE=01000, BRANCH=11000. Any other opcode is illegal.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
  - Otherwise hold.
- DECODE: opcode_q<=opcode. alu_src_a=00, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - Legal opcode: go to EXEC. Illegal opcode: go to FAULT.
- EXEC, by opcode_q:
  - R: a=01, b=00, op=10, go to WB.
  - I-ALU: a=01, b=10, op=11, go to WB.
  - LOAD/STORE: a=01, b=10, op=00, go to MEM.
  - BRANCH: a=01, b=00, op=01, pc_write_cond=1, pc_src=1, retire=1, go to FETCH.
- MEM: mem_req=1, i_or_d=1, mem_we=(opcode_q==STORE).
  - On mem_ready: STORE gets retire=1 and goes to FETCH. LOAD goes to WB.
  - Otherwise hold. mem_we stays high for the whole wait.
- WB: reg_write=1, mem_to_reg=(opcode_q==LOAD), retire=1, go to FETCH.
- FAULT: all controls 0, fault=1. Exit only via rst.
- Timeout counter:
  - Clears on any transition into FETCH or MEM.
  - Increments each cycle mem_req=1 and mem_ready=0, saturating.
  - If counter==MEM_TIMEOUT-1 and mem_ready=0: go to FAULT next edge.
  - mem_ready in that same cycle wins: the access completes normally.
- Latency per instruction with zero-wait memory: branch=3 cycles, R/I-ALU/store=4, load=5.
- At most one retire per instruction. retire and fault are never high together.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode localparams (shared with the single-cycle decoder)
  - state encodings
  - ALUOp codes
  - alu_src_a/alu_src_b select codes
- One sub-module, mem_timeout_ctr (clear, enable, expired flag, parameterised by MEM_TIMEOUT/TO_W), instantiated once.

Test Plan:
- Reset then R-type (opcode=01100), mem_ready tied 1: states 0,1,2,4. reg_write=1, mem_to_reg=0 in cycle 4. retire pulses once. Next FETCH in cycle 5.
- LOAD (00000) with mem_ready delayed 3 cycles in MEM: mem_req=1, i_or_d=1, mem_we=0 held 4 cycles. Then WB with mem_to_reg=1, total 8 cycles.
- STORE (01000), mem_ready=1 first MEM cycle: mem_we=1 for exactly one cycle. retire in that cycle. reg_write never asserted.
- BRANCH (11000): EXEC asserts pc_write_cond=1, pc_src=1, alu_op=01, retire=1. Returns to FETCH after 3 cycles.
- Illegal opcode 11111 in DECODE goes to FAULT: fault=1, all controls 0, held for 20 cycles until rst=1. The next cycle is FETCH.
- FETCH with mem_ready=0 for 16 cycles (MEM_TIMEOUT=16) goes to FAULT. Repeat with mem_ready=1 on cycle 16: ir_write=1, no fault. Assert rst in MEM of a store: mem_we=0 during reset, FETCH afterwards.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcode, state and datapath-select codes for the RV32I control
package rv_ctrl_pkg;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] SRC_A_PC   = 2'b00;
    localparam logic [1:0] SRC_A_RS1  = 2'b01;
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    function automatic logic is_legal(input logic [4:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - saturating wait counter flagging an overlong memory access
module mem_timeout_ctr #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != {TO_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - Moore sequencing controller for the multi-cycle RV32I core
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       retire,
    output logic       fault
);

    state_t     state;
    state_t     nxt;
    logic [4:0] opcode_q;
    logic       expired;
    logic       to_clr;
    logic       to_en;

    // Reset forces every control low so an aborted store can never strobe mem_we.
    always_comb begin
        nxt           = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        retire        = 1'b0;
        fault         = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        nxt      = S_DECODE;
                    end else if (expired) begin
                        nxt = S_FAULT;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRC_B_IMM;
                    nxt       = is_legal(opcode) ? S_EXEC : S_FAULT;
                end
                S_EXEC: begin
                    alu_src_a = SRC_A_RS1;
                    case (opcode_q)
                        OP_R: begin
                            alu_op = ALU_RTYPE;
                            nxt    = S_WB;
                        end
                        OP_I: begin
                            alu_src_b = SRC_B_IMM;
                            alu_op    = ALU_ITYPE;
                            nxt       = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_b = SRC_B_IMM;
                            nxt       = S_MEM;
                        end
                        OP_BRANCH: begin
                            alu_op        = ALU_BR;
                            pc_write_cond = 1'b1;
                            pc_src        = 1'b1;
                            retire        = 1'b1;
                            nxt           = S_FETCH;
                        end
                        default: nxt = S_FAULT;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                    mem_we  = (opcode_q == OP_STORE);
                    if (mem_ready) begin
                        retire = (opcode_q == OP_STORE);
                        nxt    = (opcode_q == OP_STORE) ? S_FETCH : S_WB;
                    end else if (expired) begin
                        nxt = S_FAULT;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opcode_q == OP_LOAD);
                    retire     = 1'b1;
                    nxt        = S_FETCH;
                end
                S_FAULT: fault = 1'b1;
                default: nxt = S_FAULT;
            endcase
        end
    end

    // Counter restarts on entry to either memory-waiting state, not while holding in one.
    assign to_clr = (nxt != state) && ((nxt == S_FETCH) || (nxt == S_MEM));
    assign to_en  = mem_req && !mem_ready;

    mem_timeout_ctr #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TO_W       (TO_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (to_clr),
        .en     (to_en),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            opcode_q <= '0;
        end else begin
            state <= nxt;
            if (state == S_DECODE) begin
                opcode_q <= opcode;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - scoreboard bench for the multi-cycle control FSM
module tb_multicycle_ctrl_fsm;

    localparam logic [4:0] R_OP  = 5'b01100;
    localparam logic [4:0] I_OP  = 5'b00100;
    localparam logic [4:0] LD_OP = 5'b00000;
    localparam logic [4:0] ST_OP = 5'b01000;
    localparam logic [4:0] BR_OP = 5'b11000;
    localparam logic [4:0] BAD_OP = 5'b11111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       retire;
        logic       fault;
    } ctl_t;

    typedef struct {
        logic       rst;
        logic [4:0] opc;
        logic       rdy;
        ctl_t       exp;
    } stim_t;

    logic       clk;
    logic       rst;
    logic [4:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       reg_write, mem_to_reg, retire, fault;

    int   n_run  = 0;
    int   n_fail = 0;
    ctl_t sb[$];

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(16), .TO_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .i_or_d       (i_or_d),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .pc_src       (pc_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .retire       (retire),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t e_zero();
        return '0;
    endfunction

    function automatic ctl_t e_fetch(input logic rdy);
        ctl_t c = '0;
        c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
        return c;
    endfunction

    function automatic ctl_t e_decode();
        ctl_t c = '0;
        c.alu_src_b = 2'b10;
        return c;
    endfunction

    function automatic ctl_t e_exec(input logic [1:0] b, input logic [1:0] op, input logic br);
        ctl_t c = '0;
        c.alu_src_a = 2'b01; c.alu_src_b = b; c.alu_op = op;
        c.pc_write_cond = br; c.pc_src = br; c.retire = br;
        return c;
    endfunction

    function automatic ctl_t e_mem(input logic store, input logic rdy);
        ctl_t c = '0;
        c.mem_req = 1'b1; c.i_or_d = 1'b1; c.mem_we = store; c.retire = store & rdy;
        return c;
    endfunction

    function automatic ctl_t e_wb(input logic load);
        ctl_t c = '0;
        c.reg_write = 1'b1; c.mem_to_reg = load; c.retire = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_fault();
        ctl_t c = '0;
        c.fault = 1'b1;
        return c;
    endfunction

    function automatic stim_t mk(input logic r, input logic [4:0] o, input logic d, input ctl_t e);
        stim_t s;
        s.rst = r; s.opc = o; s.rdy = d; s.exp = e;
        return s;
    endfunction

    function automatic ctl_t sample();
        ctl_t c;
        c.mem_req = mem_req; c.mem_we = mem_we; c.i_or_d = i_or_d;
        c.ir_write = ir_write; c.pc_write = pc_write; c.pc_write_cond = pc_write_cond;
        c.pc_src = pc_src; c.alu_src_a = alu_src_a; c.alu_src_b = alu_src_b;
        c.alu_op = alu_op; c.reg_write = reg_write; c.mem_to_reg = mem_to_reg;
        c.retire = retire; c.fault = fault;
        return c;
    endfunction

    task automatic test_reset();
        stim_t s[$];
        ctl_t  got, want;
        s.push_back(mk(1, ST_OP, 1, e_zero()));
        s.push_back(mk(1, ST_OP, 1, e_zero()));
        s.push_back(mk(0, ST_OP, 0, e_fetch(0)));
        foreach (s[i]) begin
            rst = s[i].rst; opcode = s[i].opc; mem_ready = s[i].rdy;
            sb.push_back(s[i].exp);
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        stim_t s[$];
        ctl_t  got, want;
        s.push_back(mk(1, R_OP, 1, e_zero()));
        s.push_back(mk(0, R_OP, 1, e_fetch(1)));
        s.push_back(mk(0, R_OP, 1, e_decode()));
        s.push_back(mk(0, R_OP, 1, e_exec(2'b00, 2'b10, 0)));
        s.push_back(mk(0, R_OP, 1, e_wb(0)));
        s.push_back(mk(0, R_OP, 0, e_fetch(0)));
        foreach (s[i]) begin
            rst = s[i].rst; opcode = s[i].opc; mem_ready = s[i].rdy;
            sb.push_back(s[i].exp);
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL rtype cycle %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        stim_t s[$];
        ctl_t  got, want;
        s.push_back(mk(1, LD_OP, 1, e_zero()));
        s.push_back(mk(0, LD_OP, 1, e_fetch(1)));
        s.push_back(mk(0, LD_OP, 1, e_decode()));
        s.push_back(mk(0, LD_OP, 1, e_exec(2'b10, 2'b00, 0)));
        for (int k = 0; k < 3; k++) s.push_back(mk(0, LD_OP, 0, e_mem(0, 0)));
        s.push_back(mk(0, LD_OP, 1, e_mem(0, 1)));
        s.push_back(mk(0, LD_OP, 1, e_wb(1)));
        s.push_back(mk(0, LD_OP, 0, e_fetch(0)));
        foreach (s[i]) begin
            rst = s[i].rst; opcode = s[i].opc; mem_ready = s[i].rdy;
            sb.push_back(s[i].exp);
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL load cycle %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_branch();
        stim_t s[$];
        ctl_t  got, want;
        s.push_back(mk(1, ST_OP, 1, e_zero()));
        s.push_back(mk(0, ST_OP, 1, e_fetch(1)));
        s.push_back(mk(0, ST_OP, 1, e_decode()));
        s.push_back(mk(0, ST_OP, 1, e_exec(2'b10, 2'b00, 0)));
        s.push_back(mk(0, ST_OP, 1, e_mem(1, 1)));
        s.push_back(mk(0, BR_OP, 1, e_fetch(1)));
        s.push_back(mk(0, BR_OP, 1, e_decode()));
        s.push_back(mk(0, BR_OP, 1, e_exec(2'b00, 2'b01, 1)));
        s.push_back(mk(0, BR_OP, 0, e_fetch(0)));
        foreach (s[i]) begin
            rst = s[i].rst; opcode = s[i].opc; mem_ready = s[i].rdy;
            sb.push_back(s[i].exp);
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL store_branch cycle %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        ctl_t  got, want;
        s.push_back(mk(1, R_OP, 1, e_zero()));
        s.push_back(mk(0, R_OP, 1, e_fetch(1)));
        s.push_back(mk(0, R_OP, 1, e_decode()));
        s.push_back(mk(0, I_OP, 1, e_exec(2'b00, 2'b10, 0)));
        s.push_back(mk(0, I_OP, 1, e_wb(0)));
        s.push_back(mk(0, I_OP, 1, e_fetch(1)));
        s.push_back(mk(0, I_OP, 1, e_decode()));
        s.push_back(mk(0, R_OP, 1, e_exec(2'b10, 2'b11, 0)));
        s.push_back(mk(0, R_OP, 1, e_wb(0)));
        s.push_back(mk(0, R_OP, 0, e_fetch(0)));
        foreach (s[i]) begin
            rst = s[i].rst; opcode = s[i].opc; mem_ready = s[i].rdy;
            sb.push_back(s[i].exp);
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        stim_t s[$];
        ctl_t  got, want;
        s.push_back(mk(1, BAD_OP, 1, e_zero()));
        s.push_back(mk(0, BAD_OP, 1, e_fetch(1)));
        s.push_back(mk(0, BAD_OP, 1, e_decode()));
        for (int k = 0; k < 20; k++) s.push_back(mk(0, R_OP, 1, e_fault()));
        s.push_back(mk(1, R_OP, 1, e_zero()));
        s.push_back(mk(0, R_OP, 0, e_fetch(0)));
        foreach (s[i]) begin
            rst = s[i].rst; opcode = s[i].opc; mem_ready = s[i].rdy;
            sb.push_back(s[i].exp);
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL illegal cycle %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        stim_t s[$];
        ctl_t  got, want;
        s.push_back(mk(1, R_OP, 0, e_zero()));
        for (int k = 0; k < 16; k++) s.push_back(mk(0, R_OP, 0, e_fetch(0)));
        s.push_back(mk(0, R_OP, 0, e_fault()));
        s.push_back(mk(0, R_OP, 1, e_fault()));
        s.push_back(mk(1, R_OP, 0, e_zero()));
        for (int k = 0; k < 15; k++) s.push_back(mk(0, R_OP, 0, e_fetch(0)));
        s.push_back(mk(0, R_OP, 1, e_fetch(1)));
        s.push_back(mk(0, R_OP, 1, e_decode()));
        s.push_back(mk(0, R_OP, 1, e_exec(2'b00, 2'b10, 0)));
        s.push_back(mk(0, R_OP, 1, e_wb(0)));
        foreach (s[i]) begin
            rst = s[i].rst; opcode = s[i].opc; mem_ready = s[i].rdy;
            sb.push_back(s[i].exp);
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL timeout cycle %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_mem();
        stim_t s[$];
        ctl_t  got, want;
        s.push_back(mk(0, ST_OP, 1, e_fetch(1)));
        s.push_back(mk(0, ST_OP, 1, e_decode()));
        s.push_back(mk(0, ST_OP, 1, e_exec(2'b10, 2'b00, 0)));
        s.push_back(mk(0, ST_OP, 0, e_mem(1, 0)));
        s.push_back(mk(0, ST_OP, 0, e_mem(1, 0)));
        s.push_back(mk(1, ST_OP, 1, e_zero()));
        s.push_back(mk(0, ST_OP, 0, e_fetch(0)));
        foreach (s[i]) begin
            rst = s[i].rst; opcode = s[i].opc; mem_ready = s[i].rdy;
            sb.push_back(s[i].exp);
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_in_mem cycle %0d: got %h expected %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        opcode = '0;
        mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_load_wait();
        test_store_branch();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_in_mem();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
